addsub_operand_loader: RTL and testbench
========================================

// Module: addsub_operand_loader
// PURPOSE
//  Front-end stage that sequentially loads two WIDTH-bit operands from board switches
//  using a push button, then presents them to the downstream 4-bit adder/subtracter.
//  Raw buttons are synchronized and debounced. A/B/sub are held stable while op_valid=1.
//  Sits between board I/O (switches, buttons) and the adder's a/b inputs.
// PARAMETERS
//  WIDTH            4       operand width; must match the downstream adder
//  DEBOUNCE_CYCLES  500000  consecutive stable synchronized cycles needed to accept a level (>=2)
//  SYNC_STAGES      2       synchronizer flops per raw async input (>=2)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  sw         in   WIDTH  operand switches (quasi-static, sampled at load)
//  btn_load   in   1      raw load button, active-high, bouncy, async
//  btn_clear  in   1      raw clear button, active-high, bouncy, async
//  sub_sel    in   1      raw mode switch: 0 = add, 1 = subtract
//  a          out  WIDTH  operand A to adder
//  b          out  WIDTH  operand B to adder
//  sub        out  1      mode latched with B
//  op_valid   out  1      1 = a/b/sub form a complete, stable operation
//  state_led  out  2      FSM state code, for board LEDs
// BEHAVIOUR
//  Reset (async assert, sync release): a=0, b=0, sub=0, op_valid=0, state=S_WAIT_A (2'b00),
//   debouncers at level 0 with counters cleared, synchronizer flops 0.
//  Sync: btn_load, btn_clear and sub_sel each pass through SYNC_STAGES flops.
//  Debounce: a per-button counter restarts whenever the sync level differs from the accepted
//   level. The accepted level toggles after DEBOUNCE_CYCLES consecutive differing cycles.
//   The counter is idle while sync level == accepted level.
//  Pulses: load_p / clear_p = one-cycle pulse on each 0->1 transition of the accepted level.
//   There is no pulse on release. Holding a button gives exactly one pulse.
//  FSM (registers update at the edge after the pulse cycle):
//   S_WAIT_A (00): load_p -> a<=sw, go S_WAIT_B
//   S_WAIT_B (01): load_p -> b<=sw, sub<=sync sub_sel, op_valid<=1, go S_VALID
//   S_VALID  (10): load_p -> a<=sw, op_valid<=0, go S_WAIT_B (new op; b and sub keep old value
//                  until recaptured)
//   any state: clear_p -> a=b=sub=0, op_valid=0, go S_WAIT_A
//   2'b11 is unreachable; it decodes to S_WAIT_A.
//  Simultaneous load_p and clear_p: clear wins.
//  Latency: a clean press gives load_p SYNC_STAGES+DEBOUNCE_CYCLES cycles after the raw edge.
//   Operand/op_valid are updated 1 cycle after load_p.
//  sub_sel is not debounced. It is sampled only at B capture; changes at other times are ignored.
//  Bounce shorter than DEBOUNCE_CYCLES on either edge gives no pulse and no state change.
//  Reset mid-debounce or mid-sequence aborts everything; no pulse is generated on release.
//  state_led = state code. op_valid == (state==S_VALID) at all times.
// STRUCTURE
//  Shared package addsub_pkg:
//   - state localparams S_WAIT_A/S_WAIT_B/S_VALID
//   - default operand width ADDSUB_WIDTH=4, also used by the adder
//  Sub-module input_debouncer:
//   - params SYNC_STAGES, DEBOUNCE_CYCLES
//   - ports clk, rst_n, raw, level, rise_p
//   - instantiated for btn_load and btn_clear
//  sub_sel uses a plain synchronizer in the top level.
//  Counter width is $clog2(DEBOUNCE_CYCLES+1).
// TESTING  (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//  1 Reset: rst_n=0 mid-clock -> all outputs 0 immediately, state_led=00.
//    Release -> outputs hold until a press.
//  2 Add flow: sw=4'h3, clean load press; sw=4'h5, sub_sel=0, load press
//    -> a=3, b=5, sub=0, op_valid=1, state_led=10; load_p seen 6 cycles after each raw edge.
//  3 Bounce: btn_load toggles 1,0,1,0 with 2-cycle periods, then stays 0 -> no pulse, state unchanged.
//    Next stable press of >=6 cycles -> exactly one capture.
//  4 Hold: btn_load held 100 cycles -> single capture. sub_sel toggled while in S_VALID
//    -> sub unchanged.
//  5 Clear priority: load and clear pressed on the same raw edge in S_WAIT_B
//    -> S_WAIT_A, a=b=sub=0, op_valid=0.
//  6 Restart from S_VALID (a=3, b=5, sub=1): sw=4'hF, load -> a=F, op_valid=0, state_led=01.
//    Then sw=4'h1, load -> b=1, op_valid=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Package: addsub_pkg
// Shared definitions for the add/subtract datapath: the default operand width
// (also used by the downstream adder) and the operand-loader state codes.
// The state codes double as the board LED pattern, so their encodings are fixed.
package addsub_pkg;

    localparam int ADDSUB_WIDTH = 4;

    // 2'b11 is never entered; the loader decodes it like S_WAIT_A.
    typedef enum logic [1:0] {
        S_WAIT_A = 2'b00,
        S_WAIT_B = 2'b01,
        S_VALID  = 2'b10
    } state_t;

endpackage

// File: rtl/input_debouncer.sv
// Module: input_debouncer
// Synchronizes one raw asynchronous button and debounces it.
// The accepted level toggles only after DEBOUNCE_CYCLES consecutive cycles
// in which the synchronized input differs from it.
// Ports:
//   clk     in  1  system clock, rising edge
//   rst_n   in  1  asynchronous active-low reset
//   raw     in  1  raw bouncy button, active-high
//   level   out 1  debounced (accepted) level
//   rise_p  out 1  one-cycle pulse on each accepted 0->1 transition
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_p
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // NOTE: every flop here is reset, including the synchronizer chain, so a
    // press in progress at reset can never leak through as a pulse afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            rise_p <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous
            // stage's old value, which is what turns this into a shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            rise_p <= 1'b0;
            if (sync_lvl == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
                cnt    <= '0;
                level  <= sync_lvl;
                rise_p <= sync_lvl;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/addsub_operand_loader.sv
// Module: addsub_operand_loader
// Loads operand A, then operand B plus the add/subtract mode, from board
// switches using a debounced load button; a clear button restarts the sequence.
// a/b/sub are held stable whenever op_valid is 1.
// Ports:
//   clk        in  1      system clock, rising edge
//   rst_n      in  1      asynchronous active-low reset
//   sw         in  WIDTH  operand switches, sampled at load
//   btn_load   in  1      raw load button (bouncy, async)
//   btn_clear  in  1      raw clear button (bouncy, async)
//   sub_sel    in  1      raw mode switch: 0 = add, 1 = subtract
//   a, b       out WIDTH  operands to the adder
//   sub        out 1      mode latched together with B
//   op_valid   out 1      a/b/sub form a complete, stable operation
//   state_led  out 2      FSM state code
module addsub_operand_loader
    import addsub_pkg::*;
#(
    parameter int WIDTH           = ADDSUB_WIDTH,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clear,
    input  logic             sub_sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             sub,
    output logic             op_valid,
    output logic [1:0]       state_led
);

    logic [1:0]             rst_sync;
    logic                   rst_int_n;
    logic [SYNC_STAGES-1:0] sub_sync_q;
    logic                   load_p;
    logic                   clear_p;
    state_t                 state;

    // Reset asserts asynchronously but releases on a clock edge, so no flop
    // sees rst_n deassert close to its active edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    // The mode switch is only synchronized; it is read once, at B capture.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) sub_sync_q <= '0;
        else            sub_sync_q <= {sub_sync_q[SYNC_STAGES-2:0], sub_sel};
    end

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_db (
        .clk   (clk),
        .rst_n (rst_int_n),
        .raw   (btn_load),
        .level (),
        .rise_p(load_p)
    );

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk   (clk),
        .rst_n (rst_int_n),
        .raw   (btn_clear),
        .level (),
        .rise_p(clear_p)
    );

    // Clear is tested first so it wins over a coincident load.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state    <= S_WAIT_A;
            a        <= '0;
            b        <= '0;
            sub      <= 1'b0;
            op_valid <= 1'b0;
        end else if (clear_p) begin
            state    <= S_WAIT_A;
            a        <= '0;
            b        <= '0;
            sub      <= 1'b0;
            op_valid <= 1'b0;
        end else if (load_p) begin
            case (state)
                S_WAIT_B: begin
                    b        <= sw;
                    sub      <= sub_sync_q[SYNC_STAGES-1];
                    op_valid <= 1'b1;
                    state    <= S_VALID;
                end
                S_VALID: begin
                    // New operation: b and sub stay until B is recaptured.
                    a        <= sw;
                    op_valid <= 1'b0;
                    state    <= S_WAIT_B;
                end
                default: begin
                    a     <= sw;
                    state <= S_WAIT_B;
                end
            endcase
        end
    end

    assign state_led = state;

endmodule

// File: tb/tb_addsub_operand_loader.sv
// Testbench: tb_addsub_operand_loader
// Scoreboard bench: each press pushes the expected output snapshot; a negedge
// monitor pops and compares whenever the observable outputs change.
module tb_addsub_operand_loader;

    localparam int W   = 4;
    localparam int DEB = 4;
    localparam int SYN = 2;
    localparam int LAT = SYN + DEB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw = '0;
    logic         btn_load = 1'b0;
    logic         btn_clear = 1'b0;
    logic         sub_sel = 1'b0;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         op_valid;
    logic [1:0]   state_led;

    int           checks = 0;
    int           errors = 0;
    int           load_cnt = 0;
    int           clear_cnt = 0;
    logic [11:0]  sb[$];
    bit           mon_en = 1'b0;
    logic [11:0]  prev = '0;
    logic [11:0]  cur;

    addsub_operand_loader #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_load (btn_load),
        .btn_clear(btn_clear),
        .sub_sel  (sub_sel),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .op_valid (op_valid),
        .state_led(state_led)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pack(input logic [3:0] ea, input logic [3:0] eb,
                                         input logic es, input logic ev,
                                         input logic [1:0] st);
        return {st, ev, es, ea, eb};
    endfunction

    function automatic logic [11:0] snap();
        return {state_led, op_valid, sub, a, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse counters and output scoreboard monitor.
    always @(negedge clk) begin
        if (dut.load_p === 1'b1)  load_cnt++;
        if (dut.clear_p === 1'b1) clear_cnt++;
        if (mon_en) begin
            cur = snap();
            if (cur !== prev) begin
                if (sb.size() == 0) check("unexpected_change", cur, prev);
                else                check("scb_out", cur, sb.pop_front());
                prev = cur;
            end
        end
    end

    // Clean press of the given buttons for 'hold' cycles, then release and settle.
    task automatic press(input logic ld, input logic cl, input int hold);
        int l0;
        int c0;
        l0 = load_cnt;
        c0 = clear_cnt;
        btn_load  = ld;
        btn_clear = cl;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (i == LAT - 1) check("pulse_early", {dut.load_p, dut.clear_p}, 2'b00);
            if (i == LAT)     check("pulse_at_lat", {dut.load_p, dut.clear_p}, {ld, cl});
        end
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("load_pulses", load_cnt - l0, {31'd0, ld});
        check("clear_pulses", clear_cnt - c0, {31'd0, cl});
    endtask

    initial begin
        int l0;

        // 1 Reset
        #1 check("rst_out", snap(), 12'h000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_hold", snap(), 12'h000);
        prev   = snap();
        mon_en = 1'b1;

        // 2 Add flow
        sw = 4'h3;
        sb.push_back(pack(4'h3, 4'h0, 1'b0, 1'b0, 2'b01));
        press(1'b1, 1'b0, 8);
        sw = 4'h5;
        sub_sel = 1'b0;
        sb.push_back(pack(4'h3, 4'h5, 1'b0, 1'b1, 2'b10));
        press(1'b1, 1'b0, 8);
        check("add_a", a, 4'h3);
        check("add_b", b, 4'h5);
        check("add_valid", {op_valid, state_led}, 3'b110);

        // 4 Hold: one capture from a 100-cycle press, then sub_sel ignored in S_VALID
        sw = 4'h9;
        sb.push_back(pack(4'h9, 4'h5, 1'b0, 1'b0, 2'b01));
        press(1'b1, 1'b0, 100);
        sw = 4'h7;
        sub_sel = 1'b1;
        sb.push_back(pack(4'h9, 4'h7, 1'b1, 1'b1, 2'b10));
        press(1'b1, 1'b0, 8);
        for (int i = 0; i < 6; i++) begin
            sub_sel = ~sub_sel;
            repeat (3) @(negedge clk);
        end
        check("sub_hold", sub, 1'b1);

        // 3 Bounce: pulses shorter than the debounce window are dropped
        l0 = load_cnt;
        sw = 4'h2;
        btn_load = 1'b1; repeat (2) @(negedge clk);
        btn_load = 1'b0; repeat (2) @(negedge clk);
        btn_load = 1'b1; repeat (2) @(negedge clk);
        btn_load = 1'b0; repeat (20) @(negedge clk);
        check("bounce_pulses", load_cnt - l0, 0);
        check("bounce_state", state_led, 2'b10);
        sb.push_back(pack(4'h2, 4'h7, 1'b1, 1'b0, 2'b01));
        press(1'b1, 1'b0, 6);

        // 5 Clear priority in S_WAIT_B
        sb.push_back(pack(4'h0, 4'h0, 1'b0, 1'b0, 2'b00));
        press(1'b1, 1'b1, 8);
        check("clr_state", {op_valid, state_led}, 3'b000);

        // 6 Restart from S_VALID
        sw = 4'h3;
        sb.push_back(pack(4'h3, 4'h0, 1'b0, 1'b0, 2'b01));
        press(1'b1, 1'b0, 8);
        sw = 4'h5;
        sub_sel = 1'b1;
        sb.push_back(pack(4'h3, 4'h5, 1'b1, 1'b1, 2'b10));
        press(1'b1, 1'b0, 8);
        sw = 4'hF;
        sb.push_back(pack(4'hF, 4'h5, 1'b1, 1'b0, 2'b01));
        press(1'b1, 1'b0, 8);
        check("restart_state", {op_valid, state_led}, 3'b001);
        sw = 4'h1;
        sb.push_back(pack(4'hF, 4'h1, 1'b1, 1'b1, 2'b10));
        press(1'b1, 1'b0, 8);
        check("restart_b", b, 4'h1);

        // Clear from S_VALID
        sb.push_back(pack(4'h0, 4'h0, 1'b0, 1'b0, 2'b00));
        press(1'b0, 1'b1, 8);

        // Reset mid-sequence and mid-debounce
        sw = 4'h3;
        sb.push_back(pack(4'h3, 4'h0, 1'b0, 1'b0, 2'b01));
        press(1'b1, 1'b0, 8);
        sw = 4'h5;
        l0 = load_cnt;
        btn_load = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("rst_mid", snap(), 12'h000);
        btn_load = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_abort", snap(), 12'h000);
        check("rst_no_pulse", load_cnt - l0, 0);

        check("scb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
